// File: rtl/button_debouncer.sv
// Push-button conditioner: per-channel 2-flop synchroniser, integrating debounce
// filter and registered rise/fall pulses. Sticky press flags exist only when BTN_STICKY_EN is defined.
module button_debouncer #(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_BTN-1:0] i_btn_raw,
    input  logic [NUM_BTN-1:0] i_clr_sticky,
    output logic [NUM_BTN-1:0] o_btn_level,
    output logic [NUM_BTN-1:0] o_btn_rise,
    output logic [NUM_BTN-1:0] o_btn_fall,
    output logic [NUM_BTN-1:0] o_btn_sticky
);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_SETTLING = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [NUM_BTN-1:0] r_sync1;
    logic [NUM_BTN-1:0] r_sync2;
    logic [NUM_BTN-1:0] w_polarity;

    assign w_polarity = {NUM_BTN{ACTIVE_LOW}};

    // Polarity is normalised at the first flop so everything downstream sees 1 = pressed.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_btn_raw ^ w_polarity;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        state_t           r_state;
        state_t           w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic             r_level;
        logic             w_level_nxt;
        logic             r_rise;
        logic             w_rise_nxt;
        logic             r_fall;
        logic             w_fall_nxt;

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_state <= ST_STABLE;
                r_cnt   <= '0;
                r_level <= 1'b0;
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_level <= w_level_nxt;
                r_rise  <= w_rise_nxt;
                r_fall  <= w_fall_nxt;
            end
        end

        // NOTE: every signal driven here gets a default first so no latch is inferred.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_level_nxt = r_level;
            w_rise_nxt  = 1'b0;
            w_fall_nxt  = 1'b0;
            case (r_state)
                ST_STABLE: begin
                    w_cnt_nxt = '0;
                    if (r_sync2[g] != r_level) begin
                        w_state_nxt = ST_SETTLING;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end
                ST_SETTLING: begin
                    if (r_sync2[g] == r_level) begin
                        w_state_nxt = ST_STABLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt >= CNT_LAST) begin
                        // Accept the new level; the >= compare keeps the counter from ever wrapping.
                        w_state_nxt = ST_STABLE;
                        w_cnt_nxt   = '0;
                        w_level_nxt = r_sync2[g];
                        w_rise_nxt  = r_sync2[g];
                        w_fall_nxt  = ~r_sync2[g];
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        assign o_btn_level[g] = r_level;
        assign o_btn_rise[g]  = r_rise;
        assign o_btn_fall[g]  = r_fall;

`ifdef BTN_STICKY_EN
        logic r_sticky;

        // A press arriving with a clear must not be lost, so set has priority.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_sticky <= 1'b0;
            end else if (r_rise) begin
                r_sticky <= 1'b1;
            end else if (i_clr_sticky[g]) begin
                r_sticky <= 1'b0;
            end
        end

        assign o_btn_sticky[g] = r_sticky;
`else
        assign o_btn_sticky[g] = 1'b0;
`endif
    end

`ifndef BTN_STICKY_EN
    logic w_unused_clr;
    assign w_unused_clr = ^i_clr_sticky;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer with DEBOUNCE_CYCLES=4: stimulus queues expected
// pulse events, a monitor checks every cycle's pulses and level against them.
module tb_button_debouncer;

    localparam int NB = 4;
    localparam int LAT = 6;
`ifdef BTN_STICKY_EN
    localparam logic [NB-1:0] STICKY_ON = 4'h1;
`else
    localparam logic [NB-1:0] STICKY_ON = 4'h0;
`endif

    typedef struct {
        int            at;
        logic [NB-1:0] rise;
        logic [NB-1:0] fall;
        logic [NB-1:0] level;
    } evt_t;

    logic          clk;
    logic          rst;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] clr_sticky;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_rise;
    logic [NB-1:0] btn_fall;
    logic [NB-1:0] btn_sticky;

    int   cyc = 0;
    int   n_total = 0;
    int   n_bad = 0;
    evt_t sb_q[$];
    logic [NB-1:0] exp_level = '0;

    button_debouncer #(
        .NUM_BTN        (NB),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3),
        .ACTIVE_LOW     (1'b0)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_btn_raw   (btn_raw),
        .i_clr_sticky(clr_sticky),
        .o_btn_level (btn_level),
        .o_btn_rise  (btn_rise),
        .o_btn_fall  (btn_fall),
        .o_btn_sticky(btn_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Raw change driven now is first sampled at the next edge; level moves LAT edges later.
    task automatic expect_evt(input logic [NB-1:0] rise, input logic [NB-1:0] fall,
                              input logic [NB-1:0] level);
        evt_t e;
        e.at    = cyc + LAT;
        e.rise  = rise;
        e.fall  = fall;
        e.level = level;
        sb_q.push_back(e);
    endtask

    // Monitor: samples 1 time unit after the falling edge, away from both clock edges.
    always begin
        evt_t e;
        @(negedge clk);
        #1;
        if (rst) begin
            check("reset_outputs", {btn_level, btn_rise, btn_fall, btn_sticky}, 32'h0);
            exp_level = '0;
        end else begin
            if ((btn_rise | btn_fall) != '0) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_pulse", {btn_rise, btn_fall}, 32'h0);
                end else begin
                    e = sb_q.pop_front();
                    check("evt_cycle", cyc, e.at);
                    check("evt_rise", btn_rise, e.rise);
                    check("evt_fall", btn_fall, e.fall);
                    exp_level = e.level;
                end
            end
            check("rise_and_fall", btn_rise & btn_fall, 32'h0);
            check("level", btn_level, exp_level);
        end
    end

    initial begin
        rst        = 1'b1;
        btn_raw    = 4'hF;
        clr_sticky = 4'h0;

        // 1: reset with all buttons held, then release
        wait_cyc(3);
        check("reset_level_direct", btn_level, 32'h0);
        rst = 1'b0;
        expect_evt(4'hF, 4'h0, 4'hF);
        wait_cyc(8);
        btn_raw = 4'h0;
        expect_evt(4'h0, 4'hF, 4'h0);
        wait_cyc(8);

        // 2: clean press and release of button 0
        btn_raw = 4'h1;
        expect_evt(4'h1, 4'h0, 4'h1);
        wait_cyc(8);
        btn_raw = 4'h0;
        expect_evt(4'h0, 4'h1, 4'h0);
        wait_cyc(8);

        // 3: button 1 bounces, then settles high
        for (int i = 0; i < 2; i++) begin
            btn_raw = 4'h2;
            wait_cyc(2);
            btn_raw = 4'h0;
            wait_cyc(2);
        end
        btn_raw = 4'h2;
        expect_evt(4'h2, 4'h0, 4'h2);
        wait_cyc(8);
        btn_raw = 4'h0;
        expect_evt(4'h0, 4'h2, 4'h0);
        wait_cyc(8);

        // 4: 3-cycle glitch on button 2 must be rejected
        btn_raw = 4'h4;
        wait_cyc(3);
        btn_raw = 4'h0;
        wait_cyc(10);

        // 5: reset in the middle of a count on button 3
        btn_raw = 4'h8;
        wait_cyc(3);
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        expect_evt(4'h8, 4'h0, 4'h8);
        wait_cyc(8);
        btn_raw = 4'h0;
        expect_evt(4'h0, 4'h8, 4'h0);
        wait_cyc(8);

        // 6: sticky flag on button 0
        check("sticky_after_reset", btn_sticky, 32'h0);
        btn_raw = 4'h1;
        expect_evt(4'h1, 4'h0, 4'h1);
        wait_cyc(8);
        check("sticky_set", btn_sticky, STICKY_ON);
        btn_raw = 4'h0;
        expect_evt(4'h0, 4'h1, 4'h0);
        wait_cyc(8);
        check("sticky_hold_release", btn_sticky, STICKY_ON);
        clr_sticky = 4'h1;
        wait_cyc(1);
        clr_sticky = 4'h0;
        check("sticky_clear", btn_sticky, 32'h0);
        btn_raw = 4'h1;
        expect_evt(4'h1, 4'h0, 4'h1);
        wait_cyc(LAT);
        clr_sticky = 4'h1;
        wait_cyc(1);
        clr_sticky = 4'h0;
        check("sticky_set_wins", btn_sticky, STICKY_ON);
        wait_cyc(2);
        check("sticky_persist", btn_sticky, STICKY_ON);
        btn_raw = 4'h0;
        expect_evt(4'h0, 4'h1, 4'h0);
        wait_cyc(8);

        check("scoreboard_drained", sb_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
